// File: rtl/reg_file_wb_pkg.sv
// Shared register-file definitions: the `define header used by the
// destination select, the control unit and the register file, plus a
// package exposing the same values as typed localparams.
`ifndef REG_FILE_WB_DEFS
`define REG_FILE_WB_DEFS
`define REG_ZERO 5'd0
`define REG_RA   5'd31
`define REG_DW   32
`define REG_AW   5
`endif

package reg_file_wb_pkg;

  localparam int REG_DW    = `REG_DW;
  localparam int REG_AW    = `REG_AW;
  localparam int REG_DEPTH = 1 << REG_AW;

  // Architectural register numbers with special meaning.
  localparam logic [REG_AW-1:0] REG_ZERO = `REG_ZERO;
  localparam logic [REG_AW-1:0] REG_RA   = `REG_RA;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  // Mask that removes register $0 from any per-register strobe vector.
  function automatic logic [REG_DEPTH-1:0] zero_reg_mask();
    logic [REG_DEPTH-1:0] m;
    m    = '1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/reg_file_wb_dec5to32.sv
// One-hot address decoder with enable: the inverse of the 5-bit
// destination select. Output bit n is high when en is high and sel == n.
module dec5to32 #(
  parameter int AW = 5
) (
  input  logic                 en,
  input  logic [AW-1:0]        sel,
  output logic [(1<<AW)-1:0]   onehot
);

  localparam int DEPTH = 1 << AW;

  // One comparator per output line; en is tested first so that an
  // unknown sel with en low still yields an all-zero vector.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
      always_comb begin
        onehot[gi] = 1'b0;
        if (en) begin
          onehot[gi] = (sel == gi[AW-1:0]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/reg_file_wb.sv
// 32 x 32-bit MIPS general-purpose register file: one write port with
// one-hot strobe decode, two combinational read ports with optional
// same-cycle write-to-read bypass, and $0 hardwired to zero.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DW     = REG_DW,
  parameter int AW     = REG_AW,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int DEPTH = 1 << AW;
  localparam int NPORT = 2;

  logic [DEPTH-1:0] dec_out;
  logic [DEPTH-1:0] wr_strobe;
  logic             wr_en;
  logic             wr_nonzero;
  logic [DW-1:0]    data_reg [DEPTH];

  // Writes are ignored while reset is held; the decoder sees no enable.
  assign wr_en      = we & ~rst;
  assign wr_nonzero = (waddr != '0);

  dec5to32 #(
    .AW (AW)
  ) u_dec (
    .en     (wr_en),
    .sel    (waddr),
    .onehot (dec_out)
  );

  // Strobe bit 0 is forced low so a write to $0 is discarded.
  always_comb begin
    wr_strobe    = dec_out;
    wr_strobe[0] = 1'b0;
  end

  // Per-register storage. Entry 0 never sees a strobe and stays at its
  // reset value, so synthesis reduces it to a constant.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      // Asynchronous clear, strobe-gated load of the write-back data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi] <= '0;
        end else if (wr_strobe[gi]) begin
          data_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  logic [AW-1:0] raddr_v [NPORT];
  logic [DW-1:0] rdata_v [NPORT];

  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;
  assign rdata1     = rdata_v[0];
  assign rdata2     = rdata_v[1];

  // Independent read ports: forced zero during reset and for $0, then the
  // in-flight write data on an address match (when bypass is built in),
  // otherwise the stored value.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rport
      logic hit;

      // A bypass hit needs an enabled, non-$0 write to the same register.
      always_comb begin
        hit = 1'b0;
        if (BYPASS) begin
          hit = wr_en && wr_nonzero && (raddr_v[gi] == waddr);
        end
      end

      // Read data selection for this port.
      always_comb begin
        rdata_v[gi] = data_reg[raddr_v[gi]];
        if (rst || (raddr_v[gi] == '0)) begin
          rdata_v[gi] = '0;
        end else if (hit) begin
          rdata_v[gi] = wdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: one instance with bypass and one
// without share the same stimulus. The stimulus process predicts the
// read data of both instances and the write strobe from a plain array
// model and queues it; a monitor on the falling edge compares.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1_b, rdata2_b;
  logic [31:0] rdata1_n, rdata2_n;

  reg_file_wb #(.DW(32), .AW(5), .BYPASS(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_b),
    .rdata2 (rdata2_b)
  );

  reg_file_wb #(.DW(32), .AW(5), .BYPASS(1'b0)) dut_nb (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_n),
    .rdata2 (rdata2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] r1b;
    logic [31:0] r2b;
    logic [31:0] r1n;
    logic [31:0] r2n;
    logic [31:0] strobe;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          txn_id = 0;
  logic [31:0] model [32];

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Predicted read value for one port from the architectural rules.
  function automatic logic [31:0] predict(input logic [4:0] ra, input bit bypass,
                                          input bit r, input bit w,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (r || ra == 5'd0) return 32'h0;
    if (bypass && w && wa != 5'd0 && wa == ra) return wd;
    return model[ra];
  endfunction

  // One cycle of stimulus: inputs change just after the rising edge.
  // rst_hold keeps reset high across the next edge; pulse asserts reset
  // briefly between edges and releases it before the sample point.
  task automatic txn(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra1, input logic [4:0] ra2,
                     input bit rst_hold, input bit pulse);
    exp_t e;
    logic [31:0] stb;
    @(posedge clk);
    #1;
    we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
    rst = rst_hold;
    if (pulse) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
    end
    if (rst_hold || pulse) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
    stb = 32'h0;
    if (w && !rst_hold && wa != 5'd0) stb[wa] = 1'b1;
    e.id     = txn_id;
    e.ra1    = ra1;
    e.ra2    = ra2;
    e.r1b    = predict(ra1, 1'b1, rst_hold, w, wa, wd);
    e.r2b    = predict(ra2, 1'b1, rst_hold, w, wa, wd);
    e.r1n    = predict(ra1, 1'b0, rst_hold, w, wa, wd);
    e.r2n    = predict(ra2, 1'b0, rst_hold, w, wa, wd);
    e.strobe = stb;
    exp_q.push_back(e);
    txn_id++;
    if (!rst_hold && w && wa != 5'd0) model[wa] = wd;
  endtask

  // Monitor: compare everything the DUTs present mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %0d ra1=%0d ra2=%0d rd1=%h rd2=%h nb1=%h nb2=%h",
               e.id, e.ra1, e.ra2, rdata1_b, rdata2_b, rdata1_n, rdata2_n);
      check("rdata1_bypass", e.id, rdata1_b, e.r1b);
      check("rdata2_bypass", e.id, rdata2_b, e.r2b);
      check("rdata1_nobypass", e.id, rdata1_n, e.r1n);
      check("rdata2_nobypass", e.id, rdata2_n, e.r2n);
      check("wr_strobe", e.id, dut.wr_strobe, e.strobe);
    end
  end

  initial begin
    logic [4:0] a;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

    // Reset state, then write $5 and clear it with a mid-cycle pulse.
    txn(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b1, 1'b0);
    txn(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 1'b1);

    // Basic write/read; neighbour stays zero.
    txn(1'b1, 5'd8, 32'h12345678, 5'd1, 5'd2, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd9, 5'd8, 1'b0, 1'b0);

    // $0 protection, including a same-cycle read during the write.
    txn(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b0, 1'b0);

    // Bypass versus stored value on $3.
    txn(1'b1, 5'd3, 32'hAAAA0000, 5'd7, 5'd0, 1'b0, 1'b0);
    txn(1'b1, 5'd3, 32'h0000BBBB, 5'd3, 5'd3, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd3, 5'd8, 1'b0, 1'b0);

    // Sweep every register, then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      txn(1'b1, 5'(i), 32'h100 + i, 5'(i), 5'(31 - i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      txn(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 1'b0);
    end

    // Randomized traffic with occasional reset events.
    for (int i = 0; i < 250; i++) begin
      a = 5'($urandom_range(0, 31));
      txn(1'($urandom_range(0, 1)), a, $urandom,
          ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)),
          ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0));
    end

    // Reset colliding with a write to $31, then read after release.
    txn(1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd29, 1'b0, 1'b0);
    txn(1'b1, 5'd31, 32'h00000001, 5'd31, 5'd0, 1'b1, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 1'b0, 1'b0);

    // Unknowns on the write bus with the write disabled.
    txn(1'b1, 5'd12, 32'h5A5A5A5A, 5'd0, 5'd0, 1'b0, 1'b0);
    txn(1'b0, 5'bx, 32'hxxxxxxxx, 5'd12, 5'd31, 1'b0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", txn_id, 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
